stack_program_sequencer: RTL

//  Stores a short nibble program and replays it into stack_cpu's inbits, one nibble per clk.

---
 rtl/stack_program_sequencer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/stack_program_sequencer.sv
// stack_program_sequencer: holds a short nibble program and replays it into
// stack_cpu's inbits, holding each opcode/operand for the cycles the op needs.
module stack_program_sequencer #(
  parameter int unsigned ADDR_W    = 4,
  parameter bit          START_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [3:0]        load_data,
  input  logic              clear_prog,
  input  logic              run,
  input  logic              halt,
  output logic              cpu_rst,
  output logic [3:0]        cpu_inbits,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic [ADDR_W-1:0] pc
);

  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam int unsigned PW      = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_FETCH = 3'd2,
    S_EXEC  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wp_q, wp_d;
  logic [PW-1:0]   pc_q, pc_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [3:0]      opnd_q, opnd_d;
  logic            has_opnd_q, has_opnd_d;
  logic            cpu_rst_q, cpu_rst_d;
  logic [3:0]      inbits_q, inbits_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            full_q, full_d;

  logic [3:0]      mem_q [DEPTH];

  logic            mem_we_c;
  logic [PW-1:0]   pc_adv_c;
  logic [PW-1:0]   fetch_pc_c;
  logic [PW-1:0]   opnd_pc_c;
  logic [3:0]      fetch_op_c;
  logic [3:0]      fetch_opnd_c;
  logic [2:0]      fetch_info_c;
  logic            enter_fetch_c;

  // Op decode: {has operand, exec cycles after fetch minus one (N-2)}
  function automatic logic [2:0] op_info(input logic [3:0] op);
    logic [2:0] r;
    case (op)
      4'h1, 4'h6, 4'h7, 4'h8: r = 3'b1_01;
      4'h2, 4'h5:             r = 3'b0_01;
      4'h9, 4'hA:             r = 3'b0_10;
      default:                r = 3'b0_00;
    endcase
    return r;
  endfunction

  // Program writes happen only in IDLE, only while below capacity
  always_comb begin
    mem_we_c = (state_q == S_IDLE) && load_en && !clear_prog && (wp_q != DEPTH_P);
  end

  // Program memory write port (contents intentionally not reset)
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[wp_q[ADDR_W-1:0]] <= load_data;
    end
  end

  // Fetch address and memory reads; a same-cycle load is forwarded so that
  // run with a simultaneous load sees the nibble being written
  always_comb begin
    pc_adv_c     = pc_q + (has_opnd_q ? PW'(2) : PW'(1));
    fetch_pc_c   = (state_q == S_EXEC) ? pc_adv_c : '0;
    opnd_pc_c    = fetch_pc_c + PW'(1);
    fetch_op_c   = (mem_we_c && (fetch_pc_c == wp_q)) ? load_data
                                                      : mem_q[fetch_pc_c[ADDR_W-1:0]];
    fetch_opnd_c = 4'd0;
    if (opnd_pc_c < wp_d) begin
      fetch_opnd_c = (mem_we_c && (opnd_pc_c == wp_q)) ? load_data
                                                       : mem_q[opnd_pc_c[ADDR_W-1:0]];
    end
    fetch_info_c = op_info(fetch_op_c);
  end

  // Next-state and next-output logic; outputs are computed for the state being entered
  always_comb begin
    state_d       = state_q;
    wp_d          = wp_q;
    pc_d          = pc_q;
    cnt_d         = cnt_q;
    opnd_d        = opnd_q;
    has_opnd_d    = has_opnd_q;
    cpu_rst_d     = 1'b0;
    inbits_d      = 4'd0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    enter_fetch_c = 1'b0;

    if (state_q == S_IDLE) begin
      if (clear_prog) begin
        wp_d = '0;
      end else if (mem_we_c) begin
        wp_d = wp_q + PW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (run && (wp_d != '0)) begin
          pc_d = '0;
          if (START_RST) begin
            state_d   = S_START;
            cpu_rst_d = 1'b1;
            busy_d    = 1'b1;
          end else begin
            enter_fetch_c = 1'b1;
          end
        end
      end
      S_START: begin
        enter_fetch_c = 1'b1;
      end
      S_FETCH: begin
        state_d  = S_EXEC;
        busy_d   = 1'b1;
        inbits_d = has_opnd_q ? opnd_q : 4'd0;
      end
      S_EXEC: begin
        if (cnt_q != 2'd0) begin
          cnt_d    = cnt_q - 2'd1;
          busy_d   = 1'b1;
          inbits_d = has_opnd_q ? opnd_q : 4'd0;
        end else if (pc_adv_c >= wp_q) begin
          state_d = S_DONE;
          pc_d    = pc_adv_c;
          done_d  = 1'b1;
        end else begin
          enter_fetch_c = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (enter_fetch_c) begin
      state_d               = S_FETCH;
      pc_d                  = fetch_pc_c;
      inbits_d              = fetch_op_c;
      {has_opnd_d, cnt_d}   = fetch_info_c;
      opnd_d                = fetch_opnd_c;
      busy_d                = 1'b1;
    end

    // halt overrides every transition and silences the cpu interface
    if (halt) begin
      state_d   = S_IDLE;
      pc_d      = pc_q;
      cnt_d     = cnt_q;
      cpu_rst_d = 1'b0;
      inbits_d  = 4'd0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
    end

    full_d = (wp_d == DEPTH_P);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wp_q       <= '0;
      pc_q       <= '0;
      cnt_q      <= 2'd0;
      opnd_q     <= 4'd0;
      has_opnd_q <= 1'b0;
      cpu_rst_q  <= 1'b0;
      inbits_q   <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      opnd_q     <= opnd_d;
      has_opnd_q <= has_opnd_d;
      cpu_rst_q  <= cpu_rst_d;
      inbits_q   <= inbits_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      full_q     <= full_d;
    end
  end

  assign cpu_rst    = cpu_rst_q;
  assign cpu_inbits = inbits_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign full       = full_q;
  assign pc         = pc_q[ADDR_W-1:0];

endmodule
